// File: rtl/config_bit_monitor.sv
`default_nettype none
// ============================================================================
// Module   : config_bit_monitor
// Brief    : Synchronises tile C_bit outputs into UserCLK, debounces them,
//            and reports each committed change through a valid/ready event.
// Revision : 1.0 - initial release
// ============================================================================
module config_bit_monitor #(
  parameter int NoConfigBits  = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic                    UserCLK,
  input  logic                    Reset,
  input  logic [NoConfigBits-1:0] C_bit_in,
  output logic [NoConfigBits-1:0] C_bit_out,
  output logic                    change_valid,
  input  logic                    change_ready,
  output logic [NoConfigBits-1:0] change_mask,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PENDING = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [NoConfigBits-1:0] sync1_q, sync1_d;
  logic [NoConfigBits-1:0] sync2_q, sync2_d;
  logic [NoConfigBits-1:0] cand_q,  cand_d;
  logic [NoConfigBits-1:0] out_q,   out_d;
  logic [NoConfigBits-1:0] mask_q,  mask_d;
  logic                    valid_q, valid_d;
  logic [CNT_W-1:0]        cnt_q,   cnt_d;

  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      state_q <= IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      out_q   <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      out_q   <= out_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sync1_d = C_bit_in;
    sync2_d = sync1_q;
    cand_d  = cand_q;
    out_d   = out_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (sync2_q != out_q) begin
          cand_d  = sync2_q;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (sync2_q != cand_q) begin
          cand_d = sync2_q;
          cnt_d  = '0;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (cand_q == out_q) begin
          // Input glitched away and came back: nothing to report.
          state_d = IDLE;
        end else begin
          mask_d  = cand_q ^ out_q;
          out_d   = cand_q;
          valid_d = 1'b1;
          state_d = PENDING;
        end
      end
      PENDING: begin
        // Changes seen while waiting are picked up here on acceptance.
        if (valid_q && change_ready) begin
          valid_d = 1'b0;
          if (sync2_q != out_q) begin
            cand_d  = sync2_q;
            cnt_d   = '0;
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign C_bit_out    = out_q;
  assign change_mask  = mask_q;
  assign change_valid = valid_q;
  assign busy         = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_config_bit_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_config_bit_monitor
// Brief    : Directed stimulus with a queue scoreboard for config_bit_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_config_bit_monitor;

  logic       UserCLK = 1'b0;
  logic       Reset;
  logic [3:0] C_bit_in;
  logic [3:0] C_bit_out;
  logic       change_valid;
  logic       change_ready;
  logic [3:0] change_mask;
  logic       busy;

  config_bit_monitor #(
    .NoConfigBits (4),
    .STABLE_CYCLES(4),
    .CNT_W        (3)
  ) dut (
    .UserCLK     (UserCLK),
    .Reset       (Reset),
    .C_bit_in    (C_bit_in),
    .C_bit_out   (C_bit_out),
    .change_valid(change_valid),
    .change_ready(change_ready),
    .change_mask (change_mask),
    .busy        (busy)
  );

  always #5 UserCLK = ~UserCLK;

  typedef struct packed {
    logic [3:0] mask;
    logic [3:0] out;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge UserCLK);
    #1;
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    int n = 0;
    while (change_valid !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    check(name, {31'd0, change_valid}, 32'd1);
  endtask

  task automatic accept(input string name);
    change_ready = 1'b1;
    tick();
    change_ready = 1'b0;
    check(name, {31'd0, change_valid}, 32'd0);
  endtask

  // Monitor: pops on each handshake and enforces the hold rules while pending.
  logic       prev_valid = 1'b0;
  logic       prev_hs    = 1'b0;
  logic       prev_rst   = 1'b1;
  logic [3:0] prev_mask  = 4'h0;
  logic [3:0] prev_out   = 4'h0;

  always @(negedge UserCLK) begin
    exp_t e;
    if (prev_valid && !prev_hs && !prev_rst) begin
      check("valid_held", {31'd0, change_valid}, 32'd1);
      check("mask_frozen", {28'd0, change_mask}, {28'd0, prev_mask});
      check("out_frozen", {28'd0, C_bit_out}, {28'd0, prev_out});
    end
    if (!Reset && change_valid === 1'b1 && change_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_event", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("event_mask", {28'd0, change_mask}, {28'd0, e.mask});
        check("event_out", {28'd0, C_bit_out}, {28'd0, e.out});
      end
    end
    prev_valid = (change_valid === 1'b1);
    prev_hs    = (change_valid === 1'b1) && (change_ready === 1'b1);
    prev_rst   = Reset;
    prev_mask  = change_mask;
    prev_out   = C_bit_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    bit saw_busy;

    Reset        = 1'b1;
    C_bit_in     = 4'hA;
    change_ready = 1'b0;
    tick(2);
    check("reset_valid", {31'd0, change_valid}, 32'd0);
    check("reset_out", {28'd0, C_bit_out}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    // Startup commit of 4'hA: seven edges after reset release.
    Reset = 1'b0;
    sb.push_back('{mask: 4'hA, out: 4'hA});
    bad = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (change_valid !== 1'b0 || C_bit_out !== 4'h0) bad++;
    end
    check("startup_quiet", bad, 0);
    tick();
    check("startup_valid", {31'd0, change_valid}, 32'd1);
    check("startup_out", {28'd0, C_bit_out}, 32'hA);
    check("startup_mask", {28'd0, change_mask}, 32'hA);
    accept("startup_accept");
    check("startup_idle", {31'd0, busy}, 32'd0);

    // Two-cycle glitch to 4'hB must be filtered.
    C_bit_in = 4'hB;
    saw_busy = 1'b0;
    bad      = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) C_bit_in = 4'hA;
      tick();
      if (busy) saw_busy = 1'b1;
      if (change_valid !== 1'b0) bad++;
    end
    check("glitch_no_event", bad, 0);
    check("glitch_busy_seen", {31'd0, saw_busy}, 32'd1);
    check("glitch_busy_end", {31'd0, busy}, 32'd0);
    check("glitch_out", {28'd0, C_bit_out}, 32'hA);

    // Commit 4'h5 and leave it pending.
    C_bit_in = 4'h5;
    sb.push_back('{mask: 4'hF, out: 4'h5});
    tick(20);
    check("pend_valid", {31'd0, change_valid}, 32'd1);
    check("pend_mask", {28'd0, change_mask}, 32'hF);
    check("pend_out", {28'd0, C_bit_out}, 32'h5);

    // New input while pending stays frozen, then re-settles after accept.
    C_bit_in = 4'h6;
    tick(10);
    check("frozen_mask", {28'd0, change_mask}, 32'hF);
    check("frozen_out", {28'd0, C_bit_out}, 32'h5);
    sb.push_back('{mask: 4'h3, out: 4'h6});
    accept("pend_accept");
    tick(3);
    check("second_not_yet", {31'd0, change_valid}, 32'd0);
    tick();
    check("second_valid", {31'd0, change_valid}, 32'd1);
    check("second_out", {28'd0, C_bit_out}, 32'h6);
    check("second_mask", {28'd0, change_mask}, 32'h3);
    accept("second_accept");

    // Continuous toggling never commits and keeps busy high.
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      C_bit_in = ((i / 2) % 2 == 1) ? 4'h2 : 4'h1;
      tick();
      if (i >= 2 && busy !== 1'b1) bad++;
      if (change_valid !== 1'b0) bad++;
    end
    check("toggle_busy_no_event", bad, 0);
    C_bit_in = 4'h2;
    sb.push_back('{mask: 4'h4, out: 4'h2});
    wait_valid("toggle_settle_valid", 20);
    check("toggle_settle_out", {28'd0, C_bit_out}, 32'h2);
    accept("toggle_accept");

    // Reset while pending drops everything, then the input is re-observed.
    C_bit_in = 4'h9;
    sb.push_back('{mask: 4'hB, out: 4'h9});
    wait_valid("prereset_valid", 20);
    Reset = 1'b1;
    sb.delete();
    tick();
    Reset = 1'b0;
    check("rst_pend_valid", {31'd0, change_valid}, 32'd0);
    check("rst_pend_out", {28'd0, C_bit_out}, 32'h0);
    check("rst_pend_mask", {28'd0, change_mask}, 32'h0);
    check("rst_pend_busy", {31'd0, busy}, 32'd0);
    sb.push_back('{mask: 4'h9, out: 4'h9});
    tick(6);
    check("reobs_not_yet", {31'd0, change_valid}, 32'd0);
    tick();
    check("reobs_valid", {31'd0, change_valid}, 32'd1);
    check("reobs_out", {28'd0, C_bit_out}, 32'h9);
    accept("reobs_accept");

    tick(5);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
